fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, canonical NOP and the
// fetch packet handed from fetch to decode.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    // Sequential fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold buffer for a fetch packet that decode could not accept.
// Flush (redirect) and reset take priority over load; load over drain.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       drain,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic       vld_o,
    output fetch_pkt_t dout
);

    // Occupancy flag.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_o <= 1'b0;
        end else if (load) begin
            vld_o <= 1'b1;
        end else if (drain) begin
            vld_o <= 1'b0;
        end
    end

    // Payload is only meaningful while vld_o is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one address per cycle to a memory with a
// one-cycle registered read, presents {instr, pc} packets to decode with a
// valid/ready handshake, and parks a stalled packet in a one-entry skid
// buffer so the in-flight read is never lost.
// Optional build macro FETCH_MISALIGN_EN: a redirect to a non word-aligned
// target raises a sticky misalign_o and halts fetch until an aligned
// redirect or reset. Without it, the target's low two bits are ignored.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            misalign_o
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            req_vld_q;

    logic [XLEN-1:0] redir_pc;
    logic            redir_bad;
    logic            halted;
    logic            issue;

    logic            skid_vld;
    logic            skid_load;
    logic            skid_drain;
    fetch_pkt_t      skid_din;
    fetch_pkt_t      skid_dout;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    assign redir_pc   = redirect_pc_i;
    assign redir_bad  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halted     = misalign_q;
    assign misalign_o = misalign_q && !rst;

    // Sticky misalign flag: every redirect re-evaluates it, reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_i) begin
            misalign_q <= redir_bad;
        end
    end
`else
    logic unused_redir_lsb;

    assign redir_pc         = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign redir_bad        = 1'b0;
    assign halted           = 1'b0;
    assign unused_redir_lsb = ^redirect_pc_i[1:0];
`endif

    // Handshake, issue decision and address mux.
    always_comb begin
        if_valid_o = (skid_vld || req_vld_q) && !redirect_i && !halted && !rst;
        issue      = !rst && !redir_bad &&
                     (redirect_i || (!halted && (!if_valid_o || id_ready_i)));
        if (rst) begin
            pc_o = RESET_PC;
        end else if (redirect_i) begin
            pc_o = redir_pc;
        end else begin
            pc_o = pc_q;
        end
        skid_load  = req_vld_q && !id_ready_i && !redirect_i && !halted;
        skid_drain = skid_vld && id_ready_i && !redirect_i;
        skid_din   = '{instr: instr_i, pc: req_pc_q};
        if (skid_vld) begin
            if_instr_o = skid_dout.instr;
            if_pc_o    = skid_dout.pc;
        end else begin
            if_instr_o = instr_i;
            if_pc_o    = req_pc_q;
        end
    end

    // Request tracking: remember what was sent to memory last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            req_vld_q <= 1'b0;
        end else if (issue) begin
            pc_q      <= pc_next(pc_o);
            req_pc_q  <= pc_o;
            req_vld_q <= 1'b1;
        end else begin
            req_vld_q <= 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (redirect_i),
        .din   (skid_din),
        .vld_o (skid_vld),
        .dout  (skid_dout)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for reset/stream/stall/redirect/reset,
// a scoreboarded random-stall stream across the 32-bit wrap, and the
// misalign (or low-bit masking) corner depending on the build.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
`ifdef FETCH_MISALIGN_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .id_ready_i    (id_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o)
`ifdef FETCH_MISALIGN_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory with a one-cycle registered read.
    always @(posedge clk) instr_i <= mem_word(pc_o);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc_o;
        logic [31:0] exp_if_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rdy, input logic rd,
                                input logic [31:0] rpc, input logic v,
                                input logic [31:0] po, input logic [31:0] ip);
        vec_t t;
        t.rst = r; t.ready = rdy; t.redir = rd; t.rpc = rpc;
        t.exp_valid = v; t.exp_pc_o = po; t.exp_if_pc = ip;
        vecs.push_back(t);
    endfunction

    logic [31:0] exp_q[$];

    initial begin
        logic [31:0] e;
        logic [31:0] held_pc;
        logic        was_stalled;
        int          popped;

        rst = 1'b1; id_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;

        //   rst rdy rd  rpc            valid pc_o           if_pc
        add(1, 1, 0, 32'h0,          0, 32'h0,          32'h0);   // in reset
        add(1, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(0, 1, 0, 32'h0,          0, 32'h0,          32'h0);   // release, issue 0
        add(0, 1, 0, 32'h0,          1, 32'h4,          32'h0);
        add(0, 1, 0, 32'h0,          1, 32'h8,          32'h4);
        add(0, 0, 0, 32'h0,          1, 32'hC,          32'h8);   // stall x3
        add(0, 0, 0, 32'h0,          1, 32'hC,          32'h8);
        add(0, 0, 0, 32'h0,          1, 32'hC,          32'h8);
        add(0, 1, 0, 32'h0,          1, 32'hC,          32'h8);   // drain skid
        add(0, 1, 0, 32'h0,          1, 32'h10,         32'hC);
        add(0, 0, 0, 32'h0,          1, 32'h14,         32'h10);  // stall -> skid
        add(0, 0, 1, 32'h40,         0, 32'h40,         32'h0);   // redirect over stall
        add(0, 1, 0, 32'h0,          1, 32'h44,         32'h40);
        add(0, 1, 0, 32'h0,          1, 32'h48,         32'h44);
        add(0, 1, 1, 32'h100,        0, 32'h100,        32'h0);   // back-to-back
        add(0, 1, 1, 32'h200,        0, 32'h200,        32'h0);
        add(0, 1, 0, 32'h0,          1, 32'h204,        32'h200);
        add(0, 0, 0, 32'h0,          1, 32'h208,        32'h204); // skid full
        add(1, 0, 0, 32'h0,          0, 32'h0,          32'h0);   // reset with skid full
        add(0, 1, 0, 32'h0,          0, 32'h0,          32'h0);
        add(0, 1, 0, 32'h0,          1, 32'h4,          32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; id_ready_i = vecs[i].ready;
            redirect_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
            #1;
            check32($sformatf("row%0d_valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].exp_valid});
            check32($sformatf("row%0d_pc_o", i), pc_o, vecs[i].exp_pc_o);
            if (vecs[i].exp_valid) begin
                check32($sformatf("row%0d_if_pc", i), if_pc_o, vecs[i].exp_if_pc);
                check32($sformatf("row%0d_instr", i), if_instr_o, mem_word(vecs[i].exp_if_pc));
            end
        end

        // Random-stall stream starting just below the 32-bit wrap.
        @(negedge clk);
        rst = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF4; id_ready_i = 1'b1;
        e = 32'hFFFF_FFF4;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(e);
            e = e + 32'd4;
        end
        #1;
        check32("stream_redirect_pc_o", pc_o, 32'hFFFF_FFF4);
        popped = 0; was_stalled = 1'b0; held_pc = '0;
        for (int c = 0; c < 200 && popped < 20; c++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            id_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (was_stalled) begin
                check32("stall_hold_valid", {31'b0, if_valid_o}, 32'd1);
                check32("stall_hold_pc", if_pc_o, held_pc);
            end
            was_stalled = if_valid_o && !id_ready_i;
            held_pc = if_pc_o;
            if (if_valid_o && id_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL stream_extra actual_pc=%h required=none", if_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check32("stream_pc", if_pc_o, e);
                    check32("stream_instr", if_instr_o, mem_word(e));
                    popped++;
                end
            end
        end
        check32("stream_left", exp_q.size(), 32'd0);

`ifdef FETCH_MISALIGN_EN
        @(negedge clk);
        id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h42;
        #1;
        check32("mis_redir_valid", {31'b0, if_valid_o}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            #1;
            check32("mis_flag", {31'b0, misalign_o}, 32'd1);
            check32("mis_halt_valid", {31'b0, if_valid_o}, 32'd0);
        end
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h44;
        #1;
        check32("mis_fix_pc_o", pc_o, 32'h44);
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        check32("mis_cleared", {31'b0, misalign_o}, 32'd0);
        check32("mis_fix_valid", {31'b0, if_valid_o}, 32'd1);
        check32("mis_fix_pc", if_pc_o, 32'h44);
        check32("mis_fix_instr", if_instr_o, mem_word(32'h44));
`else
        @(negedge clk);
        id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h302;
        #1;
        check32("mask_pc_o", pc_o, 32'h300);
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        check32("mask_valid", {31'b0, if_valid_o}, 32'd1);
        check32("mask_pc", if_pc_o, 32'h300);
        check32("mask_instr", if_instr_o, mem_word(32'h300));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
